// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change dispenser.
// Coin codes are shared by the restock port and the dispense output.
package vm_pkg;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'd0,
        COIN_NICKEL  = 2'd1,
        COIN_DIME    = 2'd2,
        COIN_QUARTER = 2'd3
    } coin_e;

    localparam logic [7:0] VAL_NICKEL  = 8'd5;
    localparam logic [7:0] VAL_DIME    = 8'd10;
    localparam logic [7:0] VAL_QUARTER = 8'd25;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } chg_state_e;

endpackage

// File: rtl/vm_coin_inv.sv
// One coin-inventory counter: takes at most one coin per cycle and adds a
// restock amount, saturating at the counter maximum.
module vm_coin_inv #(
    parameter int INV_W    = 6,
    parameter int INV_INIT = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic [INV_W-1:0] add,
    output logic [INV_W-1:0] cnt
);

    localparam logic [INV_W:0] CNT_MAX = {1'b0, {INV_W{1'b1}}};

    logic [INV_W:0] sum;

    // dec is only raised while cnt > 0, so the one-bit-wider sum cannot wrap
    always_comb begin
        sum = {1'b0, cnt} + {1'b0, add} - {{INV_W{1'b0}}, dec};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= INV_W'(INV_INIT);
        end else if (sum > CNT_MAX) begin
            cnt <= CNT_MAX[INV_W-1:0];
        end else begin
            cnt <= sum[INV_W-1:0];
        end
    end

endmodule

// File: rtl/vm_change_dispenser.sv
// Change payout: greedy quarter/dime/nickel, one coin per cycle, with
// restockable per-denomination inventory and a shortfall report.
//
// state    | meaning
// IDLE     | ready for a change request
// DISPENSE | paying one coin per cycle until nothing is eligible
// DONE     | one-cycle done pulse with remain/short, then back to IDLE
module vm_change_dispenser
    import vm_pkg::*;
#(
    parameter int INV_W    = 6,
    parameter int INV_INIT = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chg_valid,
    input  logic [7:0]       chg_amt,
    output logic             chg_ready,
    input  logic             load_s,
    input  logic [1:0]       load_coin,
    input  logic [INV_W-1:0] load_cnt,
    output logic             coin_strobe,
    output logic [1:0]       coin_out,
    output logic             done,
    output logic             short,
    output logic [7:0]       remain,
    output logic [INV_W-1:0] inv_q,
    output logic [INV_W-1:0] inv_d,
    output logic [INV_W-1:0] inv_n
);

    chg_state_e       state;
    logic [7:0]       rem;

    logic             pick_q;
    logic             pick_d;
    logic             pick_n;
    logic             any_pick;
    logic [1:0]       sel_coin;
    logic [7:0]       sel_val;
    logic             dec_q;
    logic             dec_d;
    logic             dec_n;
    logic [INV_W-1:0] add_q;
    logic [INV_W-1:0] add_d;
    logic [INV_W-1:0] add_n;

    // Strict priority: the largest eligible coin always wins, no lookahead
    always_comb begin
        pick_q   = (rem >= VAL_QUARTER) && (inv_q != '0);
        pick_d   = !pick_q && (rem >= VAL_DIME) && (inv_d != '0);
        pick_n   = !pick_q && !pick_d && (rem >= VAL_NICKEL) && (inv_n != '0);
        any_pick = pick_q || pick_d || pick_n;

        sel_coin = COIN_NONE;
        sel_val  = 8'd0;
        if (pick_q) begin
            sel_coin = COIN_QUARTER;
            sel_val  = VAL_QUARTER;
        end else if (pick_d) begin
            sel_coin = COIN_DIME;
            sel_val  = VAL_DIME;
        end else if (pick_n) begin
            sel_coin = COIN_NICKEL;
            sel_val  = VAL_NICKEL;
        end

        dec_q = (state == DISPENSE) && pick_q;
        dec_d = (state == DISPENSE) && pick_d;
        dec_n = (state == DISPENSE) && pick_n;
    end

    always_comb begin
        add_q = (load_s && load_coin == COIN_QUARTER) ? load_cnt : '0;
        add_d = (load_s && load_coin == COIN_DIME)    ? load_cnt : '0;
        add_n = (load_s && load_coin == COIN_NICKEL)  ? load_cnt : '0;
    end

    vm_coin_inv #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_q (
        .clk (clk),
        .rst (rst),
        .dec (dec_q),
        .add (add_q),
        .cnt (inv_q)
    );

    vm_coin_inv #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_d (
        .clk (clk),
        .rst (rst),
        .dec (dec_d),
        .add (add_d),
        .cnt (inv_d)
    );

    vm_coin_inv #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_n (
        .clk (clk),
        .rst (rst),
        .dec (dec_n),
        .add (add_n),
        .cnt (inv_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rem         <= 8'd0;
            chg_ready   <= 1'b1;
            coin_strobe <= 1'b0;
            coin_out    <= COIN_NONE;
            done        <= 1'b0;
            short       <= 1'b0;
            remain      <= 8'd0;
        end else begin
            coin_strobe <= 1'b0;
            coin_out    <= COIN_NONE;
            done        <= 1'b0;
            short       <= 1'b0;
            remain      <= 8'd0;
            case (state)
                IDLE: begin
                    if (chg_valid) begin
                        rem       <= chg_amt;
                        chg_ready <= 1'b0;
                        state     <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (any_pick) begin
                        coin_strobe <= 1'b1;
                        coin_out    <= sel_coin;
                        rem         <= rem - sel_val;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    remain    <= rem;
                    short     <= (rem != 8'd0);
                    chg_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    chg_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench: one dispenser with full initial inventory and one
// starting empty, stepped through payouts, restocks and a mid-payout reset.
module tb_vm_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;

    logic       chg_valid;
    logic [7:0] chg_amt;
    logic       chg_ready;
    logic       load_s;
    logic [1:0] load_coin;
    logic [5:0] load_cnt;
    logic       coin_strobe;
    logic [1:0] coin_out;
    logic       done;
    logic       short;
    logic [7:0] remain;
    logic [5:0] inv_q, inv_d, inv_n;

    logic       z_chg_valid;
    logic [7:0] z_chg_amt;
    logic       z_chg_ready;
    logic       z_load_s;
    logic [1:0] z_load_coin;
    logic [5:0] z_load_cnt;
    logic       z_coin_strobe;
    logic [1:0] z_coin_out;
    logic       z_done;
    logic       z_short;
    logic [7:0] z_remain;
    logic [5:0] z_inv_q, z_inv_d, z_inv_n;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    vm_change_dispenser #(.INV_W(6), .INV_INIT(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .chg_valid   (chg_valid),
        .chg_amt     (chg_amt),
        .chg_ready   (chg_ready),
        .load_s      (load_s),
        .load_coin   (load_coin),
        .load_cnt    (load_cnt),
        .coin_strobe (coin_strobe),
        .coin_out    (coin_out),
        .done        (done),
        .short       (short),
        .remain      (remain),
        .inv_q       (inv_q),
        .inv_d       (inv_d),
        .inv_n       (inv_n)
    );

    vm_change_dispenser #(.INV_W(6), .INV_INIT(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .chg_valid   (z_chg_valid),
        .chg_amt     (z_chg_amt),
        .chg_ready   (z_chg_ready),
        .load_s      (z_load_s),
        .load_coin   (z_load_coin),
        .load_cnt    (z_load_cnt),
        .coin_strobe (z_coin_strobe),
        .coin_out    (z_coin_out),
        .done        (z_done),
        .short       (z_short),
        .remain      (z_remain),
        .inv_q       (z_inv_q),
        .inv_d       (z_inv_d),
        .inv_n       (z_inv_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_coin(input string tag, input logic [1:0] exp_coin);
        check({tag, "_strobe"}, {31'd0, coin_strobe}, {31'd0, exp_coin != 2'd0});
        check({tag, "_coin"}, {30'd0, coin_out}, {30'd0, exp_coin});
    endtask

    task automatic check_z_coin(input string tag, input logic [1:0] exp_coin);
        check({tag, "_strobe"}, {31'd0, z_coin_strobe}, {31'd0, exp_coin != 2'd0});
        check({tag, "_coin"}, {30'd0, z_coin_out}, {30'd0, exp_coin});
    endtask

    initial begin
        rst = 1'b1;
        chg_valid = 1'b0; chg_amt = 8'd0;
        load_s = 1'b0; load_coin = 2'd0; load_cnt = 6'd0;
        z_chg_valid = 1'b0; z_chg_amt = 8'd0;
        z_load_s = 1'b0; z_load_coin = 2'd0; z_load_cnt = 6'd0;
        tick();
        tick();

        // reset state
        check("rst_ready", {31'd0, chg_ready}, 32'd1);
        check_coin("rst", 2'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_short", {31'd0, short}, 32'd0);
        check("rst_remain", {24'd0, remain}, 32'd0);
        check("rst_inv_q", {26'd0, inv_q}, 32'd20);
        check("rst_inv_d", {26'd0, inv_d}, 32'd20);
        check("rst_inv_n", {26'd0, inv_n}, 32'd20);
        check("rst_z_inv_d", {26'd0, z_inv_d}, 32'd0);
        rst = 1'b0;

        // 40 cents: Q, D, N
        chg_valid = 1'b1; chg_amt = 8'd40;
        tick();
        chg_valid = 1'b0;
        check("r40_accept_ready", {31'd0, chg_ready}, 32'd0);
        check_coin("r40_accept", 2'd0);
        tick(); check_coin("r40_c1", 2'd3);
        check("r40_inv_q1", {26'd0, inv_q}, 32'd19);
        tick(); check_coin("r40_c2", 2'd2);
        tick(); check_coin("r40_c3", 2'd1);
        tick(); check_coin("r40_empty", 2'd0);
        check("r40_empty_done", {31'd0, done}, 32'd0);
        tick();
        check("r40_done", {31'd0, done}, 32'd1);
        check("r40_short", {31'd0, short}, 32'd0);
        check("r40_remain", {24'd0, remain}, 32'd0);
        check("r40_ready", {31'd0, chg_ready}, 32'd1);
        check("r40_inv_q", {26'd0, inv_q}, 32'd19);
        check("r40_inv_d", {26'd0, inv_d}, 32'd19);
        check("r40_inv_n", {26'd0, inv_n}, 32'd19);
        tick();
        check("r40_done_pulse", {31'd0, done}, 32'd0);

        // zero amount
        chg_valid = 1'b1; chg_amt = 8'd0;
        tick();
        chg_valid = 1'b0;
        tick(); check_coin("r0_c1", 2'd0);
        check("r0_early_done", {31'd0, done}, 32'd0);
        tick();
        check("r0_done", {31'd0, done}, 32'd1);
        check("r0_short", {31'd0, short}, 32'd0);
        check_coin("r0_done", 2'd0);

        // 7 cents: one nickel, residue 2
        chg_valid = 1'b1; chg_amt = 8'd7;
        tick();
        chg_valid = 1'b0;
        tick(); check_coin("r7_c1", 2'd1);
        tick(); check_coin("r7_empty", 2'd0);
        tick();
        check("r7_done", {31'd0, done}, 32'd1);
        check("r7_short", {31'd0, short}, 32'd1);
        check("r7_remain", {24'd0, remain}, 32'd2);
        check("r7_inv_n", {26'd0, inv_n}, 32'd18);

        // restock with coin code 0 does nothing
        load_s = 1'b1; load_coin = 2'd0; load_cnt = 6'd5;
        tick();
        load_s = 1'b0;
        check("noop_inv_q", {26'd0, inv_q}, 32'd19);
        check("noop_inv_d", {26'd0, inv_d}, 32'd19);
        check("noop_inv_n", {26'd0, inv_n}, 32'd18);

        // saturation
        load_s = 1'b1; load_coin = 2'd3; load_cnt = 6'd41;
        tick();
        check("sat_inv_q60", {26'd0, inv_q}, 32'd60);
        load_cnt = 6'd10;
        tick();
        load_s = 1'b0;
        check("sat_inv_q63", {26'd0, inv_q}, 32'd63);
        check("sat_inv_d", {26'd0, inv_d}, 32'd19);

        // restock and dispense of a quarter on the same edge
        chg_valid = 1'b1; chg_amt = 8'd25;
        tick();
        chg_valid = 1'b0;
        load_s = 1'b1; load_coin = 2'd3; load_cnt = 6'd1;
        tick();
        load_s = 1'b0;
        check_coin("same_c1", 2'd3);
        check("same_inv_q", {26'd0, inv_q}, 32'd63);
        tick(); check_coin("same_empty", 2'd0);
        tick();
        check("same_done", {31'd0, done}, 32'd1);
        check("same_remain", {24'd0, remain}, 32'd0);

        // empty-start instance: one dime for 30, then short 20
        z_load_s = 1'b1; z_load_coin = 2'd2; z_load_cnt = 6'd1;
        tick();
        z_load_s = 1'b0;
        check("z_inv_d1", {26'd0, z_inv_d}, 32'd1);
        z_chg_valid = 1'b1; z_chg_amt = 8'd30;
        tick();
        z_chg_valid = 1'b0;
        tick(); check_z_coin("z30_c1", 2'd2);
        tick(); check_z_coin("z30_empty", 2'd0);
        tick();
        check("z30_done", {31'd0, z_done}, 32'd1);
        check("z30_short", {31'd0, z_short}, 32'd1);
        check("z30_remain", {24'd0, z_remain}, 32'd20);
        check("z30_inv_d", {26'd0, z_inv_d}, 32'd0);

        // greedy without backtracking: 30 with no nickels pays Q, short 5
        z_load_s = 1'b1; z_load_coin = 2'd3; z_load_cnt = 6'd1;
        tick();
        z_load_s = 1'b0;
        z_chg_valid = 1'b1; z_chg_amt = 8'd30;
        tick();
        z_chg_valid = 1'b0;
        tick(); check_z_coin("zq_c1", 2'd3);
        tick(); check_z_coin("zq_empty", 2'd0);
        tick();
        check("zq_done", {31'd0, z_done}, 32'd1);
        check("zq_short", {31'd0, z_short}, 32'd1);
        check("zq_remain", {24'd0, z_remain}, 32'd5);

        // reset after the first quarter of a 75-cent payout
        chg_valid = 1'b1; chg_amt = 8'd75;
        tick();
        chg_valid = 1'b0;
        tick(); check_coin("r75_c1", 2'd3);
        check("r75_inv_q", {26'd0, inv_q}, 32'd62);
        rst = 1'b1;
        tick();
        check_coin("r75_rst", 2'd0);
        check("r75_rst_done", {31'd0, done}, 32'd0);
        check("r75_rst_inv_q", {26'd0, inv_q}, 32'd20);
        check("r75_rst_inv_d", {26'd0, inv_d}, 32'd20);
        check("r75_rst_inv_n", {26'd0, inv_n}, 32'd20);
        rst = 1'b0;
        tick();
        check("r75_post_ready", {31'd0, chg_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("r75_no_done", {31'd0, done}, 32'd0);
            check_coin("r75_quiet", 2'd0);
            tick();
        end

        // payout works normally after the abort
        chg_valid = 1'b1; chg_amt = 8'd10;
        tick();
        chg_valid = 1'b0;
        tick(); check_coin("r10_c1", 2'd2);
        tick(); check_coin("r10_empty", 2'd0);
        tick();
        check("r10_done", {31'd0, done}, 32'd1);
        check("r10_remain", {24'd0, remain}, 32'd0);
        check("r10_inv_d", {26'd0, inv_d}, 32'd19);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
